// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, access-size encodings, size legality.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE      = 2'd0;
  localparam logic [1:0] SIZE_HALF      = 2'd1;
  localparam logic [1:0] SIZE_UNALIGNED = 2'd2;
  localparam logic [1:0] SIZE_WORD      = 2'd3;

  function automatic logic size_ok(input logic [1:0] size);
    case (size)
      SIZE_BYTE, SIZE_HALF, SIZE_WORD: size_ok = 1'b1;
      SIZE_UNALIGNED:                  size_ok = 1'b0;
      default:                         size_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner select: combinational, one-hot grant; port 1 wins a tie unless pri0 is set.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       pri0,
  output logic [1:0] gnt
);

  assign gnt[1] = req1 & ~(req0 & pri0);
  assign gnt[0] = req0 & ~gnt[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter, IDLE->ACCESS->RESP: ack two cycles after the IDLE sample, one access per 3 cycles;
// requesters hold req until ack. MEM_ARB_ROUND_ROBIN_EN selects round-robin ties, else port 1 always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  input  logic [1:0]  r0_size,
  input  logic [1:0]  r1_size,
  output logic        r0_ack,
  output logic        r1_ack,
  output logic        r0_err,
  output logic        r1_err,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic        win_q;        // 1 = port 1 owns the current access
  logic        we_q;
  logic        legal_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_size_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        r0_ack_q, r1_ack_q;
  logic        r0_err_q, r1_err_q;
  logic [31:0] r0_rdata_q, r1_rdata_q;

  logic [1:0]  gnt;
  logic        pri0;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_we;
  logic        sel_legal;
  logic [31:0] rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q;               // last winner; 1 hands the next tie to port 0
  assign pri0 = ptr_q;
`else
  assign pri0 = 1'b0;
`endif

  mem_arb_pick u_pick (
    .req0 (r0_req),
    .req1 (r1_req),
    .pri0 (pri0),
    .gnt  (gnt)
  );

  always_comb begin
    sel_addr  = gnt[1] ? r1_addr  : r0_addr;
    sel_wdata = gnt[1] ? r1_wdata : r0_wdata;
    sel_size  = gnt[1] ? r1_size  : r0_size;
    sel_we    = gnt[1] ? r1_we    : r0_we;
    sel_legal = (sel_addr[31:16] == MEM_ADDR) && size_ok(sel_size);
  end

  // Writes and rejected accesses complete with zero read data.
  assign rdata_d = (legal_q && !we_q) ? mem_rdata : 32'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      legal_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_size_q  <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_err_q    <= 1'b0;
      r1_err_q    <= 1'b0;
      r0_rdata_q  <= 32'h0;
      r1_rdata_q  <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      r0_err_q <= 1'b0;
      r1_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (r0_req || r1_req) begin
            win_q       <= gnt[1];
            we_q        <= sel_we;
            legal_q     <= sel_legal;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_size_q  <= sel_size;
            mem_we_q    <= sel_legal & sel_we;
            mem_re_q    <= sel_legal & ~sel_we;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (win_q) begin
            r1_ack_q   <= 1'b1;
            r1_err_q   <= ~legal_q;
            r1_rdata_q <= rdata_d;
          end else begin
            r0_ack_q   <= 1'b1;
            r0_err_q   <= ~legal_q;
            r0_rdata_q <= rdata_d;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_q <= win_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_err    = r0_err_q;
  assign r1_err    = r1_err_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, expected completions queued at issue and compared at ack.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic        r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic [1:0]  r0_size = '0, r1_size = '0;
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  bit [31:0] mem_arr [0:255];
  bit        wr_vld  [0:255];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata = wr_vld[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : mem_init(mem_addr);

  always @(posedge clock) begin
    if (mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
      wr_vld[mem_addr[9:2]]  <= 1'b1;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) re_cnt <= re_cnt + 1;
  end

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_ADDR(16'h1000)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_size(r0_size), .r1_size(r1_size),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_err(r0_err), .r1_err(r1_err),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    if (port) begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_size = size;
    end else begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_size = size;
    end
  endtask

  // Single access on one port; returns ack latency (-1 if no ack) and the response seen.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size,
                       output int lat, output logic err, output logic [31:0] rdata);
    lat = -1; err = 1'b0; rdata = 32'h0;
    drive(port, 1'b1, we, addr, wdata, size);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (port ? r1_ack : r0_ack) begin
        lat = i;
        err = port ? r1_err : r0_err;
        rdata = port ? r1_rdata : r0_rdata;
        break;
      end
    end
    drive(port, 1'b0, we, addr, wdata, size);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests++;
    if ({r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata, mem_addr, mem_wdata,
         mem_size, mem_we, mem_re} !== '0)
      begin fails++; $display("FAIL reset_state: outputs not all zero (mem_addr=%h r0_rdata=%h)", mem_addr, r0_rdata); end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd; exp_t e; int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    issue(1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, SIZE_WORD, lat, err, rd);
    e = sb.pop_front();
    tests++;
    if (lat !== 2 || err !== e.err || rd !== e.rdata)
      begin fails++; $display("FAIL w1_write: lat=%0d err=%0b rdata=%h, want lat=2 err=%0b rdata=%h", lat, err, rd, e.err, e.rdata); end
    tests++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h1000_0010 || mem_wdata !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL mem_hold: we=%0b re=%0b addr=%h wdata=%h, want 0 0 10000010 deadbeef", mem_we, mem_re, mem_addr, mem_wdata); end
    sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF});
    issue(1'b0, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, lat, err, rd);
    e = sb.pop_front();
    tests++;
    if (lat !== 2 || err !== e.err || rd !== e.rdata)
      begin fails++; $display("FAIL r0_read: lat=%0d err=%0b rdata=%h, want lat=2 err=%0b rdata=%h", lat, err, rd, e.err, e.rdata); end
    tests++;
    if (we_cnt - we0 !== 1 || re_cnt - re0 !== 1)
      begin fails++; $display("FAIL strobe_count: we=%0d re=%0d, want 1 1", we_cnt - we0, re_cnt - re0); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; exp_t e;
    t1 = -1; t2 = -1;
    sb.push_back('{1'b1, 1'b0, mem_init(32'h1000_0000)});
    sb.push_back('{1'b1, 1'b0, mem_init(32'h1000_0004)});
    drive(1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0, SIZE_WORD);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (r1_ack) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra: unexpected r1_ack at tick %0d", i);
        end else begin
          e = sb.pop_front();
          if (r1_rdata !== e.rdata || r1_err !== e.err)
            begin fails++; $display("FAIL b2b_data: rdata=%h err=%0b, want %h %0b", r1_rdata, r1_err, e.rdata, e.err); end
        end
        if (t1 < 0) begin
          t1 = i;
          drive(1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD);
        end else begin
          t2 = i;
          drive(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD);
        end
      end
    end
    tests++;
    if (t1 !== 2 || t2 - t1 !== 3)
      begin fails++; $display("FAIL b2b_timing: first=%0d gap=%0d, want 2 3", t1, t2 - t1); end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL b2b_missing: %0d acks missing, want 0", sb.size()); sb.delete(); end
    tests++;
    if (r0_rdata !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL r0_rdata_hold: %h, want deadbeef", r0_rdata); end
  endtask

  task automatic test_reject();
    int lat; logic err; logic [31:0] rd; exp_t e; int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    sb.push_back('{1'b0, 1'b1, 32'h0});
    issue(1'b0, 1'b0, 32'h2000_0000, 32'h0, SIZE_WORD, lat, err, rd);
    e = sb.pop_front();
    tests++;
    if (lat !== 2 || err !== e.err || rd !== e.rdata)
      begin fails++; $display("FAIL bad_addr: lat=%0d err=%0b rdata=%h, want lat=2 err=%0b rdata=%h", lat, err, rd, e.err, e.rdata); end
    sb.push_back('{1'b1, 1'b1, 32'h0});
    issue(1'b1, 1'b1, 32'h1000_0040, 32'h1234_5678, SIZE_UNALIGNED, lat, err, rd);
    e = sb.pop_front();
    tests++;
    if (lat !== 2 || err !== e.err || rd !== e.rdata)
      begin fails++; $display("FAIL bad_size: lat=%0d err=%0b rdata=%h, want lat=2 err=%0b rdata=%h", lat, err, rd, e.err, e.rdata); end
    tests++;
    if (we_cnt != we0 || re_cnt != re0)
      begin fails++; $display("FAIL reject_strobes: we=%0d re=%0d, want 0 0", we_cnt - we0, re_cnt - re0); end
  endtask

  task automatic test_priority();
    int acks; logic port_obs; logic [31:0] rd; exp_t e;
    acks = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    sb.push_back('{1'b1, 1'b0, mem_init(32'h1000_0030)});
`ifdef MEM_ARB_ROUND_ROBIN_EN
    sb.push_back('{1'b0, 1'b0, mem_init(32'h1000_0020)});
`else
    sb.push_back('{1'b1, 1'b0, mem_init(32'h1000_0030)});
`endif
    sb.push_back('{1'b1, 1'b0, mem_init(32'h1000_0030)});
    drive(1'b0, 1'b1, 1'b0, 32'h1000_0020, 32'h0, SIZE_WORD);
    drive(1'b1, 1'b1, 1'b0, 32'h1000_0030, 32'h0, SIZE_WORD);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (r0_ack && r1_ack) begin
        tests++; fails++; $display("FAIL prio_both: both acks at tick %0d, want one", i);
      end else if (r0_ack || r1_ack) begin
        port_obs = r1_ack;
        rd = port_obs ? r1_rdata : r0_rdata;
        acks++;
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL prio_extra: ack on port %0d at tick %0d", port_obs, i);
        end else begin
          e = sb.pop_front();
          if (port_obs !== e.port || rd !== e.rdata)
            begin fails++; $display("FAIL prio_grant: port=%0d rdata=%h, want port=%0d rdata=%h", port_obs, rd, e.port, e.rdata); end
        end
      end
    end
    tests++;
    if (acks != 3) begin fails++; $display("FAIL prio_count: %0d acks, want 3", acks); end
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_WORD);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_WORD);
    repeat (3) tick();
  endtask

  task automatic test_reset_inflight();
    int lat, acks; exp_t e;
    lat = -1; acks = 0;
    sb.push_back('{1'b0, 1'b0, mem_init(32'h1000_0080)});
    drive(1'b0, 1'b1, 1'b0, 32'h1000_0080, 32'h0, SIZE_WORD);
    tick();
    tests++;
    if (mem_re !== 1'b1) begin fails++; $display("FAIL inflight_access: mem_re=%0b, want 1", mem_re); end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata, mem_addr, mem_wdata,
         mem_size, mem_we, mem_re} !== '0)
      begin fails++; $display("FAIL reset_async: outputs not zero (mem_re=%0b mem_addr=%h)", mem_re, mem_addr); end
    repeat (3) begin
      tick();
      if (r0_ack || r1_ack) acks++;
    end
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (r1_ack) acks++;
      if (r0_ack) begin lat = i; break; end
    end
    e = sb.pop_front();
    tests++;
    if (lat !== 2 || r0_rdata !== e.rdata || r0_err !== e.err)
      begin fails++; $display("FAIL reset_retry: lat=%0d rdata=%h err=%0b, want 2 %h %0b", lat, r0_rdata, r0_err, e.rdata, e.err); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_WORD);
    tick();
    tests++;
    if (acks != 0 || r0_ack !== 1'b0)
      begin fails++; $display("FAIL reset_drop: stray acks=%0d r0_ack=%0b, want 0 0", acks, r0_ack); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reject();
    test_priority();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR, default 16'h1000: required value of addr[31:16] for a legal access.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports r0_req, r1_req  input  1 each  request from port 0 (instruction fetch) / port 1 (load/store).
REQ-005 SHALL have ports r0_we, r1_we  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports r0_addr, r1_addr  input  32 each  byte address.
REQ-007 SHALL have ports r0_wdata, r1_wdata  input  32 each  write data.
REQ-008 SHALL have ports r0_size, r1_size  input  2 each  0 = byte, 1 = half, 2 = unaligned, 3 = word.
REQ-009 SHALL have ports r0_ack, r1_ack  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports r0_err, r1_err  output  1 each  valid with ack; access rejected.
REQ-011 SHALL have ports r0_rdata, r1_rdata  output  32 each  read data, valid with ack.
REQ-012 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_size  output  2  memory command.
REQ-013 SHALL have ports mem_we, mem_re  output  1 each  memory write / read strobe.
REQ-014 SHALL have port mem_rdata  input  32  combinational memory read data.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one state per cycle outside IDLE.
REQ-016 IDLE: if any req, SHALL select a winner, register its addr/wdata/size/we onto mem_* and enter ACCESS; else stay IDLE.
REQ-017 ACCESS: SHALL assert exactly one of mem_we (write) or mem_re (read) for exactly one cycle; mem_* held stable that cycle.
REQ-018 ACCESS: SHALL capture mem_rdata into the winner's rdata register at the closing posedge (reads); writes leave rdata 0.
REQ-019 RESP: SHALL pulse winner's ack for one cycle with err/rdata valid; loser's ack/err stay 0.
REQ-020 Latency: req seen in IDLE at cycle N -> ack in cycle N+2; throughput one access per 3 cycles.
REQ-021 Requester SHALL hold req and command fields stable until ack; req sampled again only in IDLE.
REQ-022 Reject when addr[31:16] != MEM_ADDR or size == 2: mem_we/mem_re SHALL stay 0, same latency, ack with err = 1, rdata = 0.
REQ-023 Outside ACCESS, mem_we = mem_re = 0; mem_addr/mem_wdata/mem_size hold last value.
REQ-024 Single requester: SHALL be granted regardless of priority state.
REQ-025 rdata outputs SHALL hold until the next access on that port completes.

Reset
REQ-026 reset low SHALL immediately force IDLE and zero all outputs, rdata registers, and priority pointer, regardless of clock.
REQ-027 Access in flight at reset SHALL be dropped without ack; a write already committed by the memory is not undone.
REQ-028 First arbitration after reset SHALL favour port 1.

Configuration
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL be granted to the port not granted last; pointer updates in RESP.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, port 1 always wins ties; no pointer register.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the FSM state enum and the size constants SIZE_BYTE/SIZE_HALF/SIZE_UNALIGNED/SIZE_WORD.
REQ-032 Winner selection SHALL be sub-module mem_arb_pick (req pair + pointer -> one-hot grant).

Verification
REQ-033 r1 write word 0x10000010 = 0xDEADBEEF, then r0 read 0x10000010 -> mem_we once; r0_ack cycle N+2, r0_rdata = 0xDEADBEEF, err 0.
REQ-034 r0, r1 both reads from reset, held -> r1 first; with ROUND_ROBIN_EN grants alternate r1, r0, r1; without, r1 only while held.
REQ-035 r0 read 0x20000000 -> mem_re/mem_we never asserted; r0_ack with r0_err = 1, r0_rdata = 0.
REQ-036 r1 write size = 2 -> no mem_we; r1_err = 1 on ack.
REQ-037 reset low during ACCESS -> outputs 0 immediately, no ack; after release held req re-serviced, ack 2 cycles after IDLE sample.
REQ-038 Back-to-back r1 reads of 0x10000000/0x10000004 -> acks 3 cycles apart, each rdata matches memory.
